bcd_to_bin_seq: RTL



---
 rtl/bcd_to_bin_seq_pkg.sv | 25 ++
 rtl/bcd_to_bin_seq_cond_sub3.sv | 18 +
 rtl/bcd_to_bin_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq_pkg
// Shared definitions for the keypad BCD-to-binary operand converter:
// default sizes, FSM state encoding, the digit correction constant and a
// helper that tells whether a nibble is a legal BCD digit.
// ---------------------------------------------------------------------------
package bcd_to_bin_seq_pkg;

  localparam int DIGITS_DEFAULT = 4;
  localparam int BIN_W_DEFAULT  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reverse double dabble undoes the add-3 of the forward direction.
  localparam logic [3:0] CORR_VAL = 4'd3;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_cond_sub3.sv
// ---------------------------------------------------------------------------
// cond_sub3
// Combinational BCD digit corrector for reverse double dabble.
// Ports:
//   i  in  4  digit after the right shift
//   o  out 4  i-3 when i >= 8, otherwise i unchanged
// ---------------------------------------------------------------------------
module cond_sub3
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] i,
  output logic [3:0] o
);

  // A digit >= 8 minus 3 is >= 5, so this never wraps.
  assign o = (i >= 4'd8) ? (i - CORR_VAL) : i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
// Iterative packed-BCD to binary converter (reverse double dabble). A legal
// operand takes BIN_W shift cycles; an operand with any nibble > 9 is
// rejected in one cycle with err set.
// Ports:
//   clk      in  1          system clock, rising edge
//   rst_n    in  1          synchronous active-low reset
//   start    in  1          conversion request, honoured in IDLE or DONE
//   bcd_in   in  4*DIGITS   packed BCD operand, digit 0 in [3:0]
//   busy     out 1          conversion in progress
//   done     out 1          one-cycle completion / rejection pulse
//   err      out 1          last accepted operand was not valid BCD
//   bin_out  out BIN_W      result, held between conversions
// ---------------------------------------------------------------------------
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT,
  parameter int BIN_W  = BIN_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BIN_W-1:0]    bin_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  state_t            state_reg, state_next;
  logic [BW-1:0]     bcd_reg;
  logic [BIN_W-1:0]  bin_reg;
  logic [CW-1:0]     count_reg;
  logic [BIN_W-1:0]  bin_out_reg;
  logic              err_reg;

  // Input validity: every nibble must be 0..9.
  logic [DIGITS-1:0] nib_ok;
  logic              input_ok;

  // One shift step: {bcd, bin} >> 1, then per-digit correction.
  logic [BW+BIN_W-1:0] cat_sh;
  logic [BW-1:0]       bcd_sh;
  logic [BW-1:0]       bcd_corr;
  logic [BIN_W-1:0]    bin_sh;

  assign cat_sh = {bcd_reg, bin_reg} >> 1;
  assign bcd_sh = cat_sh[BW+BIN_W-1:BIN_W];
  assign bin_sh = cat_sh[BIN_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib_ok[gi] = digit_ok(bcd_in[4*gi +: 4]);

      cond_sub3 u_cond_sub3 (
        .i (bcd_sh[4*gi +: 4]),
        .o (bcd_corr[4*gi +: 4])
      );
    end
  endgenerate

  assign input_ok = &nib_ok;

  logic accept;
  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = input_ok ? SHIFT : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (count_reg == CW'(1)) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy = (state_reg == SHIFT);
    done = (state_reg == DONE);
  end

  // Datapath: shift registers, counter, result and error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_reg     <= '0;
      bin_reg     <= '0;
      count_reg   <= '0;
      bin_out_reg <= '0;
      err_reg     <= 1'b0;
    end else if (accept) begin
      if (input_ok) begin
        bcd_reg   <= bcd_in;
        bin_reg   <= '0;
        count_reg <= CW'(BIN_W);
        err_reg   <= 1'b0;
      end else begin
        // Rejected operand: result register deliberately left untouched.
        err_reg <= 1'b1;
      end
    end else if (state_reg == SHIFT) begin
      bcd_reg   <= bcd_corr;
      bin_reg   <= bin_sh;
      count_reg <= count_reg - CW'(1);
      if (count_reg == CW'(1)) begin
        bin_out_reg <= bin_sh;
      end
    end
  end

  assign bin_out = bin_out_reg;
  assign err     = err_reg;

endmodule
